// File: rtl/comparador_serial_pkg.sv
// rtl/comparador_serial_pkg.sv - shared state encoding and helpers for the serial comparator family
package comparador_serial_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARA = 2'd1,
      FIN     = 2'd2
   } state_e;

   // Bit index register width; a 1-bit operand still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/comparador_serial_comp_bit.sv
// rtl/comparador_serial_comp_bit.sv - combinational 1-bit magnitude cell
module comp_bit (
   input  logic a,
   input  logic b,
   output logic gt,
   output logic lt
);

   assign gt = a & ~b;
   assign lt = ~a & b;

endmodule

// File: rtl/comparador_serial.sv
// rtl/comparador_serial.sv - MSB-first serial magnitude comparator with start/busy/done handshake
module comparador_serial
   import comparador_serial_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         F,
   output logic         E,
   output logic         L
);

   localparam int IW = idx_width(N);

   state_e          state_q;
   logic [N-1:0]    a_q;
   logic [N-1:0]    b_q;
   logic [IW-1:0]   idx_q;
   logic            busy_q;
   logic            done_q;
   logic            f_q;
   logic            e_q;
   logic            l_q;
   logic            bit_gt;
   logic            bit_lt;

   comp_bit u_comp_bit (
      .a  (a_q[idx_q]),
      .b  (b_q[idx_q]),
      .gt (bit_gt),
      .lt (bit_lt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         f_q     <= 1'b0;
         e_q     <= 1'b0;
         l_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  idx_q   <= IW'(N - 1);
                  f_q     <= 1'b0;
                  e_q     <= 1'b0;
                  l_q     <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= COMPARA;
               end
            end
            COMPARA: begin
               // The first differing bit from the MSB decides; equality needs every bit.
               if (bit_gt) begin
                  f_q     <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end else if (bit_lt) begin
                  l_q     <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end else if (idx_q == '0) begin
                  e_q     <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign F    = f_q;
   assign E    = e_q;
   assign L    = l_q;

endmodule

// File: tb/tb_comparador_serial.sv
// tb/tb_comparador_serial.sv - directed self-checking bench for comparador_serial (N=3)
module tb_comparador_serial;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] A;
   logic [2:0] B;
   logic       busy;
   logic       done;
   logic       F;
   logic       E;
   logic       L;

   int n_cmp = 0;
   int n_bad = 0;

   comparador_serial #(.N(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .F     (F),
      .E     (E),
      .L     (L)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses start for one edge, then counts edges until done; returns to IDLE afterwards.
   task automatic run_compare(input logic [2:0] a, input logic [2:0] b,
                              output int lat, output logic [2:0] fel);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = -1;
      fel = 3'b000;
      for (int k = 1; k <= 8 && lat < 0; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            fel = {F, E, L};
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      A = 3'b000;
      B = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b00000) begin
         n_bad++;
         $display("FAIL reset_outputs got=%b want=00000", {busy, done, F, E, L});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_msb_decides();
      @(negedge clk);
      A = 3'b100;
      B = 3'b011;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b10000) begin
         n_bad++;
         $display("FAIL t1_after_edge0 got=%b want=10000", {busy, done, F, E, L});
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b11100) begin
         n_bad++;
         $display("FAIL t1_after_edge1 got=%b want=11100", {busy, done, F, E, L});
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b00100) begin
         n_bad++;
         $display("FAIL t1_after_edge2 got=%b want=00100", {busy, done, F, E, L});
      end
   endtask

   task automatic test_lsb_decides();
      int lat;
      logic [2:0] fel;
      run_compare(3'b011, 3'b010, lat, fel);
      n_cmp++;
      if (fel !== 3'b100 || lat != 3) begin
         n_bad++;
         $display("FAIL t2_gt fel=%b lat=%0d want fel=100 lat=3", fel, lat);
      end
      run_compare(3'b010, 3'b011, lat, fel);
      n_cmp++;
      if (fel !== 3'b001 || lat != 3) begin
         n_bad++;
         $display("FAIL t2_lt fel=%b lat=%0d want fel=001 lat=3", fel, lat);
      end
   endtask

   task automatic test_equal_hold();
      int lat;
      logic [2:0] fel;
      run_compare(3'b101, 3'b101, lat, fel);
      n_cmp++;
      if (fel !== 3'b010 || lat != 3) begin
         n_bad++;
         $display("FAIL t3_eq fel=%b lat=%0d want fel=010 lat=3", fel, lat);
      end
      A = 3'b111;
      B = 3'b000;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b00010) begin
         n_bad++;
         $display("FAIL t3_hold got=%b want=00010", {busy, done, F, E, L});
      end
   endtask

   task automatic test_start_while_busy();
      @(negedge clk);
      A = 3'b011;
      B = 3'b010;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      A = 3'b000;
      B = 3'b111;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b11100) begin
         n_bad++;
         $display("FAIL t4_ignore got=%b want=11100", {busy, done, F, E, L});
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL t4_ignore_idle got=%b want=00", {busy, done});
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seen;
      @(negedge clk);
      A = 3'b100;
      B = 3'b011;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         seen[k-1] = done;
         if (k == 2) begin
            n_cmp++;
            if (busy !== 1'b0) begin
               n_bad++;
               $display("FAIL t4_b2b_idle busy=%b want=0", busy);
            end
         end
      end
      start = 1'b0;
      n_cmp++;
      if (seen !== 4'b1001) begin
         n_bad++;
         $display("FAIL t4_b2b_done edges4..1=%b want=1001", seen);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_async_reset();
      int lat;
      logic [2:0] fel;
      @(negedge clk);
      A = 3'b101;
      B = 3'b101;
      start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b00000) begin
         n_bad++;
         $display("FAIL t5_rst_compara got=%b want=00000", {busy, done, F, E, L});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      A = 3'b100;
      B = 3'b011;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, F, E, L} !== 5'b00000) begin
         n_bad++;
         $display("FAIL t5_rst_fin got=%b want=00000", {busy, done, F, E, L});
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_compare(3'b001, 3'b000, lat, fel);
      n_cmp++;
      if (fel !== 3'b100 || lat != 3) begin
         n_bad++;
         $display("FAIL t5_after fel=%b lat=%0d want fel=100 lat=3", fel, lat);
      end
   endtask

   task automatic test_sweep();
      int lat;
      int exp_lat;
      logic [2:0] fel;
      logic [2:0] exp_fel;
      logic [2:0] av;
      logic [2:0] bv;
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            av = a[2:0];
            bv = b[2:0];
            exp_fel = {a > b, a == b, a < b};
            exp_lat = 3;
            for (int i = 0; i <= 2; i++)
               if (av[i] != bv[i]) exp_lat = 3 - i;
            run_compare(av, bv, lat, fel);
            n_cmp++;
            if (fel !== exp_fel) begin
               n_bad++;
               $display("FAIL sweep_flags A=%b B=%b fel=%b want=%b", av, bv, fel, exp_fel);
            end
            n_cmp++;
            if (lat != exp_lat) begin
               n_bad++;
               $display("FAIL sweep_latency A=%b B=%b lat=%0d want=%0d", av, bv, lat, exp_lat);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_msb_decides();
      test_lsb_decides();
      test_equal_hold();
      test_start_while_busy();
      test_back_to_back();
      test_async_reset();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
